// File: rtl/memory_box_4x8_if.sv
// Bus bundle for memory_box_4x8: save/load strobes, addressing controls and read/pointer status.
// The master drives the strobes and data, the slave (the memory) returns out/out_valid/ptr/wrap.
interface memory_box_4x8_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
);
    // save/load are single-cycle strobes with no back-pressure: every edge that sees a
    // strobe high performs the access; out_valid marks the cycle after a load.
    logic                  save;
    logic                  load;
    logic [DEPTH_LOG2-1:0] addr;
    logic                  use_ptr;
    logic                  auto_inc;
    logic [WIDTH-1:0]      value;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic [DEPTH_LOG2-1:0] ptr;
    logic                  wrap;

    modport master (
        output save, load, addr, use_ptr, auto_inc, value,
        input  out, out_valid, ptr, wrap
    );

    modport slave (
        input  save, load, addr, use_ptr, auto_inc, value,
        output out, out_valid, ptr, wrap
    );
endinterface

// File: rtl/memory_box_4x8.sv
// Four-entry register memory with switch-gated read path and auto-incrementing pointer.
// Define MEMORY_BOX_WRITE_THROUGH_EN to return new data on a same-cycle save+load.
module memory_box_4x8 #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input logic               clk,
    input logic               rst,
    memory_box_4x8_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST = DEPTH_LOG2'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      out_q;
    logic                  out_valid_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic                  wrap_q;

    logic [DEPTH_LOG2-1:0] sel;
    logic                  step;
    logic [WIDTH-1:0]      rd_data;

    assign sel  = bus.use_ptr ? ptr_q : bus.addr;
    // A save and load in the same cycle are one access, so one increment.
    assign step = bus.use_ptr & bus.auto_inc & (bus.save | bus.load);

`ifdef MEMORY_BOX_WRITE_THROUGH_EN
    assign rd_data = bus.save ? bus.value : mem[sel];
`else
    assign rd_data = mem[sel];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            if (bus.save) begin
                mem[sel] <= bus.value;
            end
            out_q       <= bus.load ? rd_data : '0;
            out_valid_q <= bus.load;
            if (step) begin
                ptr_q <= ptr_q + 1'b1;
            end
            wrap_q <= step && (ptr_q == LAST);
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ptr       = ptr_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_memory_box_4x8.sv
// Directed self-checking bench for memory_box_4x8 with hand-computed expectations.
module tb_memory_box_4x8;
    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;

    memory_box_4x8_if #(.WIDTH(8), .DEPTH_LOG2(2)) bus ();

    memory_box_4x8 #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic sv, input logic ld, input logic [1:0] a,
                         input logic up, input logic ai, input logic [7:0] v);
        bus.save     = sv;
        bus.load     = ld;
        bus.addr     = a;
        bus.use_ptr  = up;
        bus.auto_inc = ai;
        bus.value    = v;
    endtask

    logic [7:0] exp_sim;

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;

        // 1. Reset holds everything at zero even with a save presented
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'hFF);
        tick();
        tick();
        check("rst_out", bus.out, 8'h00);
        check("rst_valid", 8'(bus.out_valid), 8'h00);
        check("rst_ptr", 8'(bus.ptr), 8'h00);
        rst = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        tick();
        check("post_rst_load0", bus.out, 8'h00);
        check("post_rst_valid", 8'(bus.out_valid), 8'h01);

        // 2. Explicit addressing
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'hA5);
        tick();
        check("save_no_valid", 8'(bus.out_valid), 8'h00);
        drive(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h3C);
        tick();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        tick();
        check("load_a2", bus.out, 8'hA5);
        check("load_a2_valid", 8'(bus.out_valid), 8'h01);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        tick();
        check("load_a3", bus.out, 8'h3C);
        drive(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
        tick();
        check("idle_out", bus.out, 8'h00);
        check("idle_valid", 8'(bus.out_valid), 8'h00);

        // 3. Auto-increment sweep: ptr 1,2,3,0 with wrap after the 4th access
        drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h10);
        tick();
        check("sweep_ptr1", 8'(bus.ptr), 8'h01);
        check("sweep_wrap1", 8'(bus.wrap), 8'h00);
        bus.value = 8'h11;
        tick();
        check("sweep_ptr2", 8'(bus.ptr), 8'h02);
        bus.value = 8'h12;
        tick();
        check("sweep_ptr3", 8'(bus.ptr), 8'h03);
        check("sweep_wrap3", 8'(bus.wrap), 8'h00);
        bus.value = 8'h13;
        tick();
        check("sweep_ptr0", 8'(bus.ptr), 8'h00);
        check("sweep_wrap4", 8'(bus.wrap), 8'h01);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 8'h00);
        tick();
        check("sweep_ld0", bus.out, 8'h10);
        check("sweep_ld0_wrap", 8'(bus.wrap), 8'h00);
        tick();
        check("sweep_ld1", bus.out, 8'h11);
        tick();
        check("sweep_ld2", bus.out, 8'h12);
        tick();
        check("sweep_ld3", bus.out, 8'h13);
        check("sweep_ld_wrap", 8'(bus.wrap), 8'h01);
        check("sweep_ld_ptr", 8'(bus.ptr), 8'h00);

        // 4. Simultaneous save+load on addr 1
        drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'h55);
        tick();
        drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 8'hAA);
        tick();
`ifdef MEMORY_BOX_WRITE_THROUGH_EN
        exp_sim = 8'hAA;
`else
        exp_sim = 8'h55;
`endif
        check("rw_same", bus.out, exp_sim);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        tick();
        check("rw_after", bus.out, 8'hAA);

        // 5. Pointer hold
        drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h77);
        tick();
        check("hold_pre", 8'(bus.ptr), 8'h01);
        drive(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h01);
        tick();
        bus.value = 8'h02;
        tick();
        bus.value = 8'h03;
        tick();
        check("hold_noinc", 8'(bus.ptr), 8'h01);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
        tick();
        check("hold_addr_ptr", 8'(bus.ptr), 8'h01);
        check("hold_addr_out", bus.out, 8'h03);

        // 6. Asynchronous reset mid-sequence
        drive(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 8'h00);
        tick();
        check("pre_rst_ptr", 8'(bus.ptr), 8'h02);
        check("pre_rst_out", bus.out, 8'h03);
        #3;
        rst = 1'b1;
        #1;
        check("async_ptr", 8'(bus.ptr), 8'h00);
        check("async_out", bus.out, 8'h00);
        check("async_valid", 8'(bus.out_valid), 8'h00);
        check("async_wrap", 8'(bus.wrap), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 1'b0, 1'b0, 8'h00);
            tick();
            check($sformatf("cleared_mem%0d", i), bus.out, 8'h00);
        end
        check("cleared_valid", 8'(bus.out_valid), 8'h01);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/memory_box_4x8.md
Name: memory_box_4x8

Overview:
- Four-entry, 8-bit register memory with save/load controls, modelled on the game's memory levels.
- Sits directly downstream of the 1-bit switch stage: the switch's gated enable bits arrive here as the save/load strobes.
- The read path is itself switch-gated: `out` is driven with data only while a load is presented, and is 0 otherwise.
- Adds an internal address pointer with optional auto-increment, so the block doubles as a sequential buffer.

Parameters:
- WIDTH, 8, data width of each entry and of `value`/`out`.
- DEPTH_LOG2, 2, address bits; DEPTH = 2**DEPTH_LOG2 entries (4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- save  input  1  write strobe; writes `value` into the selected entry at the clock edge.
- load  input  1  read strobe; presents the selected entry on `out` in the next cycle.
- addr  input  DEPTH_LOG2  explicit address, used when `use_ptr`=0.
- use_ptr  input  1  1 = use the internal pointer instead of `addr`.
- auto_inc  input  1  1 = pointer advances after each save or load that uses it.
- value  input  WIDTH  write data.
- out  output  WIDTH  registered read data; 0 when not loading.
- out_valid  output  1  registered; high the cycle `out` carries loaded data.
- ptr  output  DEPTH_LOG2  current pointer value.
- wrap  output  1  one-cycle pulse when the pointer wraps from DEPTH-1 to 0.

Behaviour:
- Reset (asynchronous, rst=1): all entries, `out`, `out_valid`, `ptr` and `wrap` clear to 0 immediately, regardless of clk. Any operation in flight is dropped; the first edge after rst falls is a normal cycle.
- Selected index: `sel = use_ptr ? ptr : addr`.
- Save:
  - When save=1 at an edge, mem[sel] <= value.
  - Zero-cycle write; the data is visible to a load issued in the following cycle.
- Load:
  - When load=1 at an edge, out <= mem[sel] and out_valid <= 1.
  - Latency is 1 cycle.
  - When load=0, out <= 0 and out_valid <= 0 (switch semantics: no stale data).
- Simultaneous save and load to the same sel in one cycle is read-old: `out` gets the pre-write contents, and mem[sel] takes `value`.
- Pointer update, at an edge where use_ptr=1, auto_inc=1 and (save|load)=1:
  - ptr <= ptr+1, modulo DEPTH.
  - A save and load together count as one access: one increment only.
- Wrap: `wrap` <= 1 for exactly the cycle after the pointer transitions from DEPTH-1 to 0; otherwise 0.
- The pointer is unchanged when use_ptr=0, when auto_inc=0, or when the cycle is idle. `addr` never modifies `ptr`.
- All arithmetic is unsigned, mod 2**DEPTH_LOG2; no saturation.
- No other state. An idle cycle holds memory and `ptr`, and clears `out`, `out_valid` and `wrap`.

Optional Feature:
- Macro: MEMORY_BOX_WRITE_THROUGH_EN.
- Defined: a simultaneous save+load to the same sel returns `value` (new data) on `out` the next cycle; memory update is identical.
- Undefined: read-old behaviour as specified above.
- Both builds are otherwise identical.

Test Plan:
1. Reset: rst=1 with save=1, value=8'hFF → out=0, out_valid=0, ptr=0. After release, load addr=0 → out=8'h00 next cycle.
2. Explicit addressing:
   - Writes: save addr=2 value=8'hA5; save addr=3 value=8'h3C.
   - Reads: load addr=2 → out=8'hA5, out_valid=1; next load addr=3 → out=8'h3C.
   - Idle cycle → out=0, out_valid=0.
3. Auto-increment sweep (use_ptr=1, auto_inc=1):
   - Saves 8'h10, 8'h11, 8'h12, 8'h13 → ptr steps 1,2,3,0, with wrap=1 only in the cycle after the 4th save.
   - Four loads then return 8'h10..8'h13 in order.
4. Simultaneous save+load on one entry:
   - Setup: addr=1 holds 8'h55; apply save+load with value=8'hAA.
   - Default build → out=8'h55; a following load → 8'hAA.
   - With MEMORY_BOX_WRITE_THROUGH_EN → out=8'hAA.
5. Pointer hold: use_ptr=1, auto_inc=0, three saves → ptr stays at its value. use_ptr=0 with auto_inc=1 and load → ptr unchanged.
6. Reset mid-operation:
   - Pulse rst asynchronously (between edges) during an auto-inc sequence with ptr=2.
   - → ptr=0 and out=0 immediately, all entries read back 8'h00, wrap=0.
